// File: rtl/poly_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : poly_voice_allocator
// Purpose  : Note-on/off events to NUM_VOICES voices, linear attack/release
//            ramps, LRU voice stealing. Optional macro: SUSTAIN_PEDAL_EN.
// Revision : 1.0 - initial release
// ============================================================================
module poly_voice_allocator #(
    parameter int               NUM_VOICES   = 8,
    parameter int               NOTE_W       = 7,
    parameter int               FREQ_W       = 32,
    parameter int               VOL_W        = 32,
    parameter logic [VOL_W-1:0] ATTACK_STEP  = 32'h0100_0000,
    parameter logic [VOL_W-1:0] RELEASE_STEP = 32'h0080_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ev_valid,
    output logic                         ev_ready,
    input  logic                         ev_note_on,
    input  logic [NOTE_W-1:0]            ev_note,
    input  logic [FREQ_W-1:0]            ev_freq,
    input  logic [VOL_W-1:0]             ev_level,
    input  logic                         ramp_ce,
`ifdef SUSTAIN_PEDAL_EN
    input  logic                         sustain_pedal,
`endif
    output logic [NUM_VOICES*FREQ_W-1:0] frequencies,
    output logic [NUM_VOICES*VOL_W-1:0]  voice_volumes,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         steal_pulse
);
    localparam int AW = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } vstate_t;

    vstate_t           state_q [NUM_VOICES];
    vstate_t           state_d [NUM_VOICES];
    logic [VOL_W-1:0]  vol_q   [NUM_VOICES];
    logic [VOL_W-1:0]  vol_d   [NUM_VOICES];
    logic [VOL_W-1:0]  lvl_q   [NUM_VOICES];
    logic [VOL_W-1:0]  lvl_d   [NUM_VOICES];
    logic [FREQ_W-1:0] freq_q  [NUM_VOICES];
    logic [FREQ_W-1:0] freq_d  [NUM_VOICES];
    logic [NOTE_W-1:0] note_q  [NUM_VOICES];
    logic [NOTE_W-1:0] note_d  [NUM_VOICES];
    logic [AW-1:0]     age_q   [NUM_VOICES];
    logic [AW-1:0]     age_d   [NUM_VOICES];
    logic              steal_q, steal_d;

    logic              pend_q;
    logic              ev_on_q;
    logic [NOTE_W-1:0] ev_note_q;
    logic [FREQ_W-1:0] ev_freq_q;
    logic [VOL_W-1:0]  ev_level_q;

`ifdef SUSTAIN_PEDAL_EN
    logic [NUM_VOICES-1:0] held_q, held_d;
    logic                  pedal_q;
`endif

    logic [NUM_VOICES-1:0] w_match;
    logic                  w_retrig_hit, w_idle_hit, w_rel_hit;
    logic [AW-1:0]         w_retrig_idx, w_idle_idx, w_rel_idx, w_lru_idx;
    logic [AW-1:0]         w_alloc_idx, w_old_age;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            assign frequencies[gi*FREQ_W +: FREQ_W] = freq_q[gi];
            assign voice_volumes[gi*VOL_W +: VOL_W] = vol_q[gi];
            assign voice_active[gi]                 = (state_q[gi] != ST_IDLE);
            assign w_match[gi] = ((state_q[gi] == ST_ATTACK) || (state_q[gi] == ST_SUSTAIN))
                                 && (note_q[gi] == ev_note_q);
        end
    endgenerate

    assign ev_ready    = ~pend_q;
    assign steal_pulse = steal_q;

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        w_retrig_hit = 1'b0;
        w_idle_hit   = 1'b0;
        w_rel_hit    = 1'b0;
        w_retrig_idx = '0;
        w_idle_idx   = '0;
        w_rel_idx    = '0;
        w_lru_idx    = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_retrig_hit = 1'b1;
                w_retrig_idx = AW'(i);
            end
            if (state_q[i] == ST_IDLE) begin
                w_idle_hit = 1'b1;
                w_idle_idx = AW'(i);
            end
            if (state_q[i] == ST_RELEASE) begin
                w_rel_hit = 1'b1;
                w_rel_idx = AW'(i);
            end
            if (age_q[i] == AW'(NUM_VOICES - 1)) begin
                w_lru_idx = AW'(i);
            end
        end
        if (w_idle_hit) begin
            w_alloc_idx = w_idle_idx;
        end else if (w_rel_hit) begin
            w_alloc_idx = w_rel_idx;
        end else begin
            w_alloc_idx = w_lru_idx;
        end
        w_old_age = age_q[w_alloc_idx];
    end

    always_comb begin
        steal_d = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            state_d[i] = state_q[i];
            vol_d[i]   = vol_q[i];
            lvl_d[i]   = lvl_q[i];
            freq_d[i]  = freq_q[i];
            note_d[i]  = note_q[i];
            age_d[i]   = age_q[i];
        end
`ifdef SUSTAIN_PEDAL_EN
        held_d = held_q;
`endif
        // Envelope ramp; sums carry an extra bit so the attack cannot wrap.
        if (ramp_ce) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                case (state_q[i])
                    ST_ATTACK: begin
                        if (({1'b0, vol_q[i]} + {1'b0, ATTACK_STEP}) >= {1'b0, lvl_q[i]}) begin
                            vol_d[i]   = lvl_q[i];
                            state_d[i] = ST_SUSTAIN;
                        end else begin
                            vol_d[i] = vol_q[i] + ATTACK_STEP;
                        end
                    end
                    ST_RELEASE: begin
                        if (vol_q[i] <= RELEASE_STEP) begin
                            vol_d[i]   = '0;
                            state_d[i] = ST_IDLE;
                        end else begin
                            vol_d[i] = vol_q[i] - RELEASE_STEP;
                        end
                    end
                    default: ;
                endcase
            end
        end
`ifdef SUSTAIN_PEDAL_EN
        if (pedal_q && !sustain_pedal) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (held_q[i]) begin
                    held_d[i] = 1'b0;
                    if ((state_q[i] == ST_ATTACK) || (state_q[i] == ST_SUSTAIN)) begin
                        state_d[i] = ST_RELEASE;
                    end
                end
            end
        end
`endif
        // Commit overrides whatever the ramp computed for the touched voice.
        if (pend_q) begin
            if (ev_on_q && w_retrig_hit) begin
                state_d[w_retrig_idx] = ST_ATTACK;
                vol_d[w_retrig_idx]   = vol_q[w_retrig_idx];
                lvl_d[w_retrig_idx]   = ev_level_q;
                freq_d[w_retrig_idx]  = ev_freq_q;
`ifdef SUSTAIN_PEDAL_EN
                held_d[w_retrig_idx]  = 1'b0;
`endif
            end else if (ev_on_q) begin
                steal_d = ~w_idle_hit & ~w_rel_hit;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (age_q[i] < w_old_age) begin
                        age_d[i] = age_q[i] + AW'(1);
                    end
                end
                state_d[w_alloc_idx] = ST_ATTACK;
                vol_d[w_alloc_idx]   = '0;
                lvl_d[w_alloc_idx]   = ev_level_q;
                freq_d[w_alloc_idx]  = ev_freq_q;
                note_d[w_alloc_idx]  = ev_note_q;
                age_d[w_alloc_idx]   = '0;
`ifdef SUSTAIN_PEDAL_EN
                held_d[w_alloc_idx]  = 1'b0;
`endif
            end else begin
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (w_match[i]) begin
`ifdef SUSTAIN_PEDAL_EN
                        if (sustain_pedal) begin
                            held_d[i] = 1'b1;
                        end else begin
                            state_d[i] = ST_RELEASE;
                            vol_d[i]   = vol_q[i];
                        end
`else
                        state_d[i] = ST_RELEASE;
                        vol_d[i]   = vol_q[i];
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= 1'b0;
            ev_on_q    <= 1'b0;
            ev_note_q  <= '0;
            ev_freq_q  <= '0;
            ev_level_q <= '0;
            steal_q    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= ST_IDLE;
                vol_q[i]   <= '0;
                lvl_q[i]   <= '0;
                freq_q[i]  <= '0;
                note_q[i]  <= '0;
                age_q[i]   <= AW'(i);
            end
`ifdef SUSTAIN_PEDAL_EN
            held_q  <= '0;
            pedal_q <= 1'b0;
`endif
        end else begin
            pend_q <= ev_valid & ~pend_q;
            if (ev_valid && !pend_q) begin
                ev_on_q    <= ev_note_on;
                ev_note_q  <= ev_note;
                ev_freq_q  <= ev_freq;
                ev_level_q <= ev_level;
            end
            steal_q <= steal_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                state_q[i] <= state_d[i];
                vol_q[i]   <= vol_d[i];
                lvl_q[i]   <= lvl_d[i];
                freq_q[i]  <= freq_d[i];
                note_q[i]  <= note_d[i];
                age_q[i]   <= age_d[i];
            end
`ifdef SUSTAIN_PEDAL_EN
            held_q  <= held_d;
            pedal_q <= sustain_pedal;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_voice_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_voice_allocator
// Purpose  : Scoreboard bench for poly_voice_allocator (8 voices, defaults).
// Revision : 1.0 - initial release
// ============================================================================
module tb_poly_voice_allocator;
    localparam int NV = 8;
    localparam int NW = 7;
    localparam int FW = 32;
    localparam int VW = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             ev_valid;
    logic             ev_ready;
    logic             ev_note_on;
    logic [NW-1:0]    ev_note;
    logic [FW-1:0]    ev_freq;
    logic [VW-1:0]    ev_level;
    logic             ramp_ce;
    logic [NV*FW-1:0] frequencies;
    logic [NV*VW-1:0] voice_volumes;
    logic [NV-1:0]    voice_active;
    logic             steal_pulse;
`ifdef SUSTAIN_PEDAL_EN
    logic             sustain_pedal;
`endif

    poly_voice_allocator dut (
        .clk           (clk),
        .reset         (reset),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_note_on    (ev_note_on),
        .ev_note       (ev_note),
        .ev_freq       (ev_freq),
        .ev_level      (ev_level),
        .ramp_ce       (ramp_ce),
`ifdef SUSTAIN_PEDAL_EN
        .sustain_pedal (sustain_pedal),
`endif
        .frequencies   (frequencies),
        .voice_volumes (voice_volumes),
        .voice_active  (voice_active),
        .steal_pulse   (steal_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          v;
        logic [31:0] vol;
        logic [31:0] freq;
        bit          chk_freq;
        logic [7:0]  act;
        logic        stl;
    } exp_t;

    exp_t evq[$];
    exp_t rampq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   btb    = 1'b0;

    function automatic exp_t mk(input string n, input int v, input logic [31:0] vol,
                                input logic [31:0] f, input bit cf, input logic [7:0] act,
                                input logic stl);
        exp_t e;
        e.name = n; e.v = v; e.vol = vol; e.freq = f; e.chk_freq = cf; e.act = act; e.stl = stl;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] req);
        n_chk++;
        if (actual === req) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, actual, req);
    endtask

    task automatic cmp_item(input exp_t e);
        logic [31:0] av, af;
        av = voice_volumes[e.v*VW +: VW];
        af = frequencies[e.v*FW +: FW];
        n_chk++;
        if (av === e.vol && voice_active === e.act && steal_pulse === e.stl &&
            (!e.chk_freq || af === e.freq)) begin
            n_pass++;
        end else begin
            $display("FAIL %s: v%0d vol=%h req %h, active=%b req %b, steal=%b req %b, freq=%h req %h",
                     e.name, e.v, av, e.vol, voice_active, e.act, steal_pulse, e.stl,
                     af, e.chk_freq ? e.freq : af);
        end
    endtask

    // Monitor: a commit shows as ev_ready returning high; a ramp edge as ramp_ce sampled high.
    int   cyc      = 0;
    int   last_acc = -1;
    logic acc_e    = 1'b0;
    logic ramp_e   = 1'b0;
    logic rst_e    = 1'b1;
    logic prev_rdy = 1'b1;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        acc_e  <= ev_valid & ev_ready & ~reset;
        ramp_e <= ramp_ce;
        rst_e  <= reset;
        if (!btb) begin
            last_acc <= -1;
        end else if (ev_valid && ev_ready && !reset) begin
            if (last_acc >= 0) chk("btb_accept_spacing", 64'(cyc - last_acc), 64'd2);
            last_acc <= cyc;
        end
    end

    always @(negedge clk) begin
        if (!rst_e) begin
            if (acc_e) chk("ready_low_after_accept", 64'(ev_ready), 64'd0);
            if (ev_ready && !prev_rdy) begin
                if (evq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_commit: actual=1 required=0");
                end else begin
                    cmp_item(evq.pop_front());
                end
            end
            if (ramp_e && rampq.size() != 0) cmp_item(rampq.pop_front());
        end
        prev_rdy = ev_ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic on, input logic [6:0] n, input logic [31:0] f,
                           input logic [31:0] l);
        int guard;
        guard      = 0;
        ev_valid   = 1'b1;
        ev_note_on = on;
        ev_note    = n;
        ev_freq    = f;
        ev_level   = l;
        while (!ev_ready && guard < 16) begin
            tick();
            guard++;
        end
        if (!ev_ready) begin
            n_chk++;
            $display("FAIL accept_timeout: ev_ready=%b required 1", ev_ready);
        end
        tick();
    endtask

    task automatic send(input logic on, input logic [6:0] n, input logic [31:0] f,
                        input logic [31:0] l);
        present(on, n, f, l);
        ev_valid = 1'b0;
        tick();
    endtask

    task automatic ramp();
        ramp_ce = 1'b1;
        tick();
        ramp_ce = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ev_valid = 1'b0; ev_note_on = 1'b0; ev_note = '0;
        ev_freq = '0; ev_level = '0; ramp_ce = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
        sustain_pedal = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Accepted event that is still pending when reset arrives must vanish.
        present(1'b1, 7'd50, 32'h5000, 32'h0400_0000);
        ev_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_voice_active", 64'(voice_active), 64'd0);
        chk("rst_frequencies_zero", 64'(frequencies == '0), 64'd1);
        chk("rst_volumes_zero", 64'(voice_volumes == '0), 64'd1);
        chk("rst_ev_ready", 64'(ev_ready), 64'd1);
        chk("rst_steal", 64'(steal_pulse), 64'd0);

        // Attack ramp to sustain.
        evq.push_back(mk("on60_commit", 0, 32'h0, 32'h1000, 1, 8'h01, 0));
        send(1'b1, 7'd60, 32'h1000, 32'h0400_0000);
        for (int k = 0; k < 4; k++) begin
            rampq.push_back(mk("attack_ramp", 0, 32'h0100_0000 * 32'(k + 1), 32'h0, 0, 8'h01, 0));
            ramp();
        end

        // Retrigger keeps volume and voice; voice 1 stays idle.
        evq.push_back(mk("retrig60", 0, 32'h0400_0000, 32'h1100, 1, 8'h01, 0));
        send(1'b1, 7'd60, 32'h1100, 32'h0400_0000);
        rampq.push_back(mk("retrig_ramp_clamp", 0, 32'h0400_0000, 32'h0, 0, 8'h01, 0));
        ramp();

        // Note-off, release to zero.
        evq.push_back(mk("off60", 0, 32'h0400_0000, 32'h1100, 1, 8'h01, 0));
        send(1'b0, 7'd60, 32'h0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            rampq.push_back(mk("release_ramp", 0, 32'h0380_0000 - 32'(k) * 32'h0080_0000,
                               32'h0, 0, (k == 7) ? 8'h00 : 8'h01, 0));
            ramp();
        end

        // Fill all voices, lowest idle first.
        for (int k = 0; k < 8; k++) begin
            evq.push_back(mk("fill_on", k, 32'h0, 32'h2000 + 32'(k), 1, 8'((1 << (k + 1)) - 1), 0));
            send(1'b1, 7'(60 + k), 32'h2000 + 32'(k), 32'h0400_0000);
        end

        // Oldest voice (0) stolen.
        evq.push_back(mk("steal_on70", 0, 32'h0, 32'h7000, 1, 8'hFF, 1));
        send(1'b1, 7'd70, 32'h7000, 32'h0400_0000);
        rampq.push_back(mk("after_steal_ramp", 0, 32'h0100_0000, 32'h7000, 1, 8'hFF, 0));
        ramp();

        // Back-to-back with ev_valid held high.
        evq.push_back(mk("off99_noop", 1, 32'h0100_0000, 32'h2001, 1, 8'hFF, 0));
        evq.push_back(mk("off61_release", 1, 32'h0100_0000, 32'h2001, 1, 8'hFF, 0));
        evq.push_back(mk("on80_reuse_release", 1, 32'h0, 32'h8000, 1, 8'hFF, 0));
        evq.push_back(mk("on90_steal_lru", 2, 32'h0, 32'h9000, 1, 8'hFF, 1));
        btb = 1'b1;
        present(1'b0, 7'd99, 32'h0, 32'h0);
        present(1'b0, 7'd61, 32'h0, 32'h0);
        present(1'b1, 7'd80, 32'h8000, 32'h0200_0000);
        present(1'b1, 7'd90, 32'h9000, 32'h0400_0000);
        ev_valid = 1'b0;
        btb      = 1'b0;
        tick();

        // Retrigger with a level below the current volume.
        evq.push_back(mk("retrig64_low", 4, 32'h0100_0000, 32'h4400, 1, 8'hFF, 0));
        send(1'b1, 7'd64, 32'h4400, 32'h0080_0000);
        rampq.push_back(mk("retrig_low_ramp", 4, 32'h0080_0000, 32'h4400, 1, 8'hFF, 0));
        ramp();

`ifdef SUSTAIN_PEDAL_EN
        sustain_pedal = 1'b1;
        evq.push_back(mk("off63_held", 3, 32'h0200_0000, 32'h2003, 1, 8'hFF, 0));
        send(1'b0, 7'd63, 32'h0, 32'h0);
        rampq.push_back(mk("held_attack_ramp", 3, 32'h0300_0000, 32'h0, 0, 8'hFF, 0));
        ramp();
        sustain_pedal = 1'b0;
        tick();
        rampq.push_back(mk("pedal_release_ramp", 3, 32'h0280_0000, 32'h0, 0, 8'hFF, 0));
        ramp();
`else
        evq.push_back(mk("off63_release", 3, 32'h0200_0000, 32'h2003, 1, 8'hFF, 0));
        send(1'b0, 7'd63, 32'h0, 32'h0);
        rampq.push_back(mk("off63_release_ramp", 3, 32'h0180_0000, 32'h0, 0, 8'hFF, 0));
        ramp();
`endif

        repeat (4) tick();
        chk("scoreboard_drained", 64'(evq.size() + rampq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
